// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encodings and parity helpers for uart_cfg
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Reserved mode 2'b11 behaves like PAR_NONE.
    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Parity bit for a character whose XOR-reduction is xor_data.
    function automatic logic par_bit(input logic [1:0] mode, input logic xor_data);
        return (mode == PAR_ODD) ? ~xor_data : xor_data;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - first-word fall-through FIFO used for the UART TX and RX queues
module uart_fifo #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [ADDR_BITS-1:0] r_wr_ptr;
    logic [ADDR_BITS-1:0] r_rd_ptr;
    logic [ADDR_BITS:0]   r_count;
    logic                 w_do_wr;
    logic                 w_do_rd;

    assign o_full    = (r_count == (ADDR_BITS + 1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    // A read on an empty FIFO is dropped; a write on a full one only lands if a read frees a slot.
    assign w_do_rd   = i_rd_en && !o_empty;
    assign w_do_wr   = i_wr_en && (!o_full || w_do_rd);
    // Head is forced to zero when empty so the output is defined after reset.
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage array; no reset needed since only written slots are ever presented.
    always_ff @(posedge i_clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_cfg.sv
// rtl/uart_cfg.sv - configurable UART with baud tick generator, RX/TX engines and FIFOs
module uart_cfg #(
    parameter int DATA_BITS      = 8,
    parameter int FIFO_ADDR_BITS = 4,
    parameter int DIV_BITS       = 16,
    parameter int OVERSAMPLE     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [DIV_BITS-1:0]  i_divisor,
    input  logic [1:0]           i_parity_mode,
    input  logic                 i_two_stop,
    input  logic                 i_uart_rx,
    output logic                 o_uart_tx,
    input  logic                 i_write_uart,
    input  logic [DATA_BITS-1:0] i_data_to_write,
    output logic                 o_tx_full,
    input  logic                 i_read_uart,
    output logic [DATA_BITS-1:0] o_data_to_read,
    output logic                 o_rx_empty,
    output logic                 o_tx_busy,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    input  logic                 i_clear_err
);
    import uart_pkg::*;

    localparam int               OS_BITS  = $clog2(OVERSAMPLE);
    localparam logic [OS_BITS-1:0] OS_LAST = OS_BITS'(OVERSAMPLE - 1);
    localparam logic [OS_BITS-1:0] OS_HALF = OS_BITS'(OVERSAMPLE / 2 - 1);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

    // ---------------- tick generator ----------------
    logic [DIV_BITS-1:0] r_tick_cnt;
    logic                w_tick;

    assign w_tick = (r_tick_cnt == i_divisor);

    // Counter reloads on a tick, and also silently if the divisor shrank below it.
    always_ff @(posedge i_clk) begin
        if (i_reset || (r_tick_cnt >= i_divisor)) r_tick_cnt <= '0;
        else                                      r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    // ---------------- RX path ----------------
    logic                 r_rx_meta, r_rx_sync;
    uart_state_t          r_rx_state, w_rx_state_n;
    logic [OS_BITS-1:0]   r_rx_cnt, w_rx_cnt_n;
    logic [2:0]           r_rx_bit, w_rx_bit_n;
    logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_n;
    logic [1:0]           r_rx_par, w_rx_par_n;
    logic                 r_rx_wait, w_rx_wait_n;
    logic                 r_rx_push, w_rx_push_n;
    logic                 w_par_det, w_frm_det, w_ovr_det, w_rx_full;

    // Two-flop synchroniser for the asynchronous serial input; idles high.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_uart_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // RX state and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rx_state <= ST_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= PAR_NONE;
            r_rx_wait  <= 1'b0;
            r_rx_push  <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_n;
            r_rx_cnt   <= w_rx_cnt_n;
            r_rx_bit   <= w_rx_bit_n;
            r_rx_shift <= w_rx_shift_n;
            r_rx_par   <= w_rx_par_n;
            r_rx_wait  <= w_rx_wait_n;
            r_rx_push  <= w_rx_push_n;
        end
    end

    // RX next-state: mid-bit sampling counted in ticks from the start edge.
    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_cnt_n   = r_rx_cnt;
        w_rx_bit_n   = r_rx_bit;
        w_rx_shift_n = r_rx_shift;
        w_rx_par_n   = r_rx_par;
        w_rx_wait_n  = r_rx_wait;
        w_rx_push_n  = 1'b0;
        w_par_det    = 1'b0;
        w_frm_det    = 1'b0;
        case (r_rx_state)
            ST_IDLE: begin
                if (r_rx_sync) begin
                    w_rx_wait_n = 1'b0;
                end else if (!r_rx_wait) begin
                    w_rx_state_n = ST_START;
                    w_rx_cnt_n   = '0;
                    w_rx_bit_n   = '0;
                    w_rx_par_n   = i_parity_mode;
                end
            end
            ST_START: if (w_tick) begin
                if (r_rx_cnt == OS_HALF) begin
                    w_rx_cnt_n   = '0;
                    w_rx_state_n = r_rx_sync ? ST_IDLE : ST_DATA;
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 1'b1;
                end
            end
            ST_DATA: if (w_tick) begin
                if (r_rx_cnt == OS_LAST) begin
                    w_rx_cnt_n   = '0;
                    w_rx_shift_n = {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_bit == BIT_LAST) begin
                        w_rx_state_n = par_enabled(r_rx_par) ? ST_PARITY : ST_STOP;
                    end else begin
                        w_rx_bit_n = r_rx_bit + 1'b1;
                    end
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 1'b1;
                end
            end
            ST_PARITY: if (w_tick) begin
                if (r_rx_cnt == OS_LAST) begin
                    w_rx_cnt_n   = '0;
                    w_rx_state_n = ST_STOP;
                    w_par_det    = (r_rx_sync != par_bit(r_rx_par, ^r_rx_shift));
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 1'b1;
                end
            end
            ST_STOP: if (w_tick) begin
                if (r_rx_cnt == OS_LAST) begin
                    w_rx_cnt_n   = '0;
                    w_rx_state_n = ST_IDLE;
                    // A low stop bit drops the character and blocks restart until the line idles.
                    if (r_rx_sync) w_rx_push_n = 1'b1;
                    else begin
                        w_frm_det   = 1'b1;
                        w_rx_wait_n = 1'b1;
                    end
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 1'b1;
                end
            end
            default: w_rx_state_n = ST_IDLE;
        endcase
    end

    assign w_ovr_det = r_rx_push && w_rx_full && !i_read_uart;

    // Sticky error flags; a new event outranks a simultaneous clear.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_parity_err <= w_par_det || (o_parity_err && !i_clear_err);
            o_frame_err  <= w_frm_det || (o_frame_err && !i_clear_err);
            o_overrun    <= w_ovr_det || (o_overrun && !i_clear_err);
        end
    end

    uart_fifo #(.WIDTH(DATA_BITS), .ADDR_BITS(FIFO_ADDR_BITS)) u_rx_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr_en   (r_rx_push),
        .i_wr_data (r_rx_shift),
        .i_rd_en   (i_read_uart),
        .o_rd_data (o_data_to_read),
        .o_full    (w_rx_full),
        .o_empty   (o_rx_empty)
    );

    // ---------------- TX path ----------------
    uart_state_t          r_tx_state, w_tx_state_n;
    logic [OS_BITS-1:0]   r_tx_cnt, w_tx_cnt_n;
    logic [2:0]           r_tx_bit, w_tx_bit_n;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_n;
    logic                 r_tx_pbit, w_tx_pbit_n;
    logic [1:0]           r_tx_par, w_tx_par_n;
    logic                 r_tx_two, w_tx_two_n;
    logic                 w_tx_out_n, w_tx_pop, w_tx_empty;
    logic [DATA_BITS-1:0] w_tx_head;

    assign o_tx_busy = (r_tx_state != ST_IDLE);

    // TX state, datapath and registered serial output (idles high).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_pbit  <= 1'b0;
            r_tx_par   <= PAR_NONE;
            r_tx_two   <= 1'b0;
            o_uart_tx  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_shift <= w_tx_shift_n;
            r_tx_pbit  <= w_tx_pbit_n;
            r_tx_par   <= w_tx_par_n;
            r_tx_two   <= w_tx_two_n;
            o_uart_tx  <= w_tx_out_n;
        end
    end

    // TX next-state: every bit lasts OVERSAMPLE ticks; line level follows the next state.
    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt;
        w_tx_bit_n   = r_tx_bit;
        w_tx_shift_n = r_tx_shift;
        w_tx_pbit_n  = r_tx_pbit;
        w_tx_par_n   = r_tx_par;
        w_tx_two_n   = r_tx_two;
        w_tx_pop     = 1'b0;
        w_tx_out_n   = 1'b1;
        case (r_tx_state)
            ST_IDLE: if (!w_tx_empty) begin
                w_tx_pop     = 1'b1;
                w_tx_shift_n = w_tx_head;
                w_tx_pbit_n  = par_bit(i_parity_mode, ^w_tx_head);
                w_tx_par_n   = i_parity_mode;
                w_tx_two_n   = i_two_stop;
                w_tx_cnt_n   = '0;
                w_tx_bit_n   = '0;
                w_tx_state_n = ST_START;
            end
            ST_START: if (w_tick) begin
                if (r_tx_cnt == OS_LAST) begin
                    w_tx_cnt_n   = '0;
                    w_tx_state_n = ST_DATA;
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 1'b1;
                end
            end
            ST_DATA: if (w_tick) begin
                if (r_tx_cnt == OS_LAST) begin
                    w_tx_cnt_n = '0;
                    if (r_tx_bit == BIT_LAST) begin
                        w_tx_bit_n   = '0;
                        w_tx_state_n = par_enabled(r_tx_par) ? ST_PARITY : ST_STOP;
                    end else begin
                        w_tx_bit_n   = r_tx_bit + 1'b1;
                        w_tx_shift_n = r_tx_shift >> 1;
                    end
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 1'b1;
                end
            end
            ST_PARITY: if (w_tick) begin
                if (r_tx_cnt == OS_LAST) begin
                    w_tx_cnt_n   = '0;
                    w_tx_bit_n   = '0;
                    w_tx_state_n = ST_STOP;
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 1'b1;
                end
            end
            ST_STOP: if (w_tick) begin
                if (r_tx_cnt == OS_LAST) begin
                    w_tx_cnt_n = '0;
                    if (r_tx_two && (r_tx_bit == 3'd0)) w_tx_bit_n   = 3'd1;
                    else                                w_tx_state_n = ST_IDLE;
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 1'b1;
                end
            end
            default: w_tx_state_n = ST_IDLE;
        endcase
        case (w_tx_state_n)
            ST_START:  w_tx_out_n = 1'b0;
            ST_DATA:   w_tx_out_n = w_tx_shift_n[0];
            ST_PARITY: w_tx_out_n = w_tx_pbit_n;
            default:   w_tx_out_n = 1'b1;
        endcase
    end

    uart_fifo #(.WIDTH(DATA_BITS), .ADDR_BITS(FIFO_ADDR_BITS)) u_tx_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr_en   (i_write_uart),
        .i_wr_data (i_data_to_write),
        .i_rd_en   (w_tx_pop),
        .o_rd_data (w_tx_head),
        .o_full    (o_tx_full),
        .o_empty   (w_tx_empty)
    );

endmodule

// File: doc/uart_cfg.md
UART_CFG -- requirements
Module: uart_cfg

Interface
REQ-001 Parameter DATA_BITS, default 8, SHALL set the character width (legal 5..8).
REQ-002 Parameter FIFO_ADDR_BITS, default 4, SHALL set each FIFO depth to 2**FIFO_ADDR_BITS entries.
REQ-003 Parameter DIV_BITS, default 16, SHALL set the width of the baud divisor.
REQ-004 Parameter OVERSAMPLE, default 16, SHALL set ticks per bit (even, >=8).
REQ-005 Clock and reset SHALL be: one clock, i_clk, input, 1, rising-edge clock; reset is synchronous and active-high, i_reset, input, 1.
REQ-006 i_divisor  input  DIV_BITS  tick period minus one, in i_clk cycles.
REQ-007 i_parity_mode  input  2  00 none, 01 even, 10 odd, 11 reserved (treated as none).
REQ-008 i_two_stop  input  1  1 = TX sends two stop bits.
REQ-009 i_uart_rx  input  1  serial in, asynchronous; i_uart_tx output o_uart_tx  output  1  serial out.
REQ-010 i_write_uart  input  1  push i_data_to_write (DATA_BITS) into TX FIFO; o_tx_full  output  1.
REQ-011 i_read_uart  input  1  pop RX FIFO; o_data_to_read  output  DATA_BITS  RX FIFO head (first-word fall-through); o_rx_empty  output  1.
REQ-012 o_tx_busy  output  1  TX FSM not idle; o_parity_err, o_frame_err, o_overrun  output  1 each  sticky error flags; i_clear_err  input  1  clears all three.

Function
REQ-013 Tick generator SHALL assert a one-cycle tick when its counter equals i_divisor, then reload 0; counter > i_divisor SHALL reload 0 without tick; i_divisor=0 SHALL tick every cycle.
REQ-014 i_uart_rx SHALL pass a 2-flop synchroniser before use; all RX timing is relative to the synchronised signal.
REQ-015 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE->START on synchronised low; START SHALL re-sample at tick OVERSAMPLE/2-1 and return to IDLE if high (glitch rejection), else go to DATA.
REQ-017 DATA SHALL sample each bit every OVERSAMPLE ticks, LSB first, DATA_BITS bits; then PARITY if mode even/odd, else STOP.
REQ-018 PARITY SHALL compare the sampled bit to the computed parity; mismatch sets o_parity_err and the character is still pushed.
REQ-019 STOP SHALL sample one stop bit; low sets o_frame_err, the character is discarded, and FSM waits in IDLE for line high before accepting a new start.
REQ-020 A valid character SHALL be pushed into RX FIFO the cycle after the stop sample; if RX FIFO full, character is dropped and o_overrun set.
REQ-021 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; IDLE with TX FIFO non-empty SHALL load the head, pop it the same cycle, and enter START.
REQ-022 TX SHALL drive each bit for exactly OVERSAMPLE ticks: start 0, data LSB first, optional parity, one or two stop bits (1).
REQ-023 i_parity_mode and i_two_stop SHALL be latched at frame start (RX: IDLE->START; TX: IDLE->START); mid-frame changes affect only the next frame.
REQ-024 Back-to-back TX: after last stop bit, FSM SHALL go IDLE and start the next frame on the following cycle if FIFO non-empty.
REQ-025 FIFO write when full SHALL be ignored unless a read occurs the same cycle (then both occur); read when empty SHALL be ignored; simultaneous read/write when empty performs the write only.
REQ-026 Error flags SHALL set on the cycle after detection and hold until i_clear_err; a set event coinciding with i_clear_err SHALL win (flag remains 1).

Reset
REQ-027 On i_reset: o_uart_tx=1, o_tx_busy=0, both FIFOs empty (o_rx_empty=1, o_tx_full=0), o_data_to_read=0, all error flags 0, FSMs IDLE, tick counter 0, synchroniser flops 1.
REQ-028 Reset mid-frame SHALL abort the frame; o_uart_tx SHALL be 1 the cycle after reset is sampled; no partial character is pushed.

Structure
REQ-029 Shared package uart_pkg SHALL hold the FSM state encodings and parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD).
REQ-030 The two FIFOs SHALL be instances of one sub-module uart_fifo (width, address-bits parameters); RX/TX engines and tick generator stay in uart_cfg.

Verification
REQ-031 Loopback, i_divisor=0, 8N1, write 0xA5 -> o_uart_tx frame 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; 0xA5 readable, no flags.
REQ-032 Even parity, send 0x07 into RX with parity bit 0 -> 0x07 pushed, o_parity_err=1; i_clear_err -> 0.
REQ-033 RX frame 0x3C with stop bit 0 -> o_frame_err=1, o_rx_empty stays 1.
REQ-034 Fill RX FIFO with 16 chars, send 17th (0x55) without reading -> o_overrun=1, first 16 read back in order, 0x55 absent.
REQ-035 8-cycle low pulse on i_uart_rx at i_divisor=0 -> RX returns IDLE, nothing pushed, no flags.
REQ-036 Assert i_reset during TX data bit 3 of 0xFF -> o_uart_tx=1 next cycle, o_tx_busy=0, TX FIFO empty.
